// File: rtl/fir_ahb_slave.sv
// rtl/fir_ahb_slave.sv - AHB-Lite register front end and coefficient sequencer for the FIR core
// Optional: define FIR_ERR_STICKY_EN to make status bit8 a read-to-clear copy of err.
module fir_ahb_slave #(
  parameter int NUM_COEFF = 4,
  parameter int DATA_W    = 16
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              hsel,
  input  logic [3:0]        haddr,
  input  logic              hsize,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [DATA_W-1:0] hwdata,
  output logic [DATA_W-1:0] hrdata,
  output logic              hready,
  output logic              hresp,
  input  logic              modwait,
  input  logic              err,
  input  logic [DATA_W-1:0] fir_out,
  output logic              data_ready,
  output logic              load_coeff,
  output logic [DATA_W-1:0] sample_data,
  output logic [DATA_W-1:0] fir_coefficient
);
  localparam int IDX_W = (NUM_COEFF > 1) ? $clog2(NUM_COEFF) : 1;

  typedef enum logic [1:0] {C_IDLE, C_REQ, C_WAIT} cstate_e;

  logic              valid_q, valid_d;
  logic [3:0]        addr_q, addr_d;
  logic              size_q, size_d;
  logic              write_q, write_d;
  logic              err2_q, err2_d;
  logic              dr_q, dr_d;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic [DATA_W-1:0] coeff_q [NUM_COEFF];
  logic [DATA_W-1:0] coeff_d [NUM_COEFF];
  logic              ncs_q, ncs_d;
  cstate_e           cstate_q, cstate_d;
  logic [IDX_W-1:0]  idx_q, idx_d;

  logic [2:0]        reg_sel;
  logic [IDX_W-1:0]  coeff_sel;
  logic              is_sample, is_coeff, is_ncs;
  logic              bad_access, err1, seq_busy, sample_stall;
  logic              wr_done, rd_done, seq_clear, err_bit;
  logic [DATA_W-1:0] rd_val;
  logic              unused_htrans0;

  assign unused_htrans0 = htrans[0];

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_v,
                                              input logic [DATA_W-1:0] wd,
                                              input logic sz, input logic odd);
    merge = old_v;
    if (sz) merge = wd;
    else if (odd) merge[DATA_W-1:DATA_W/2] = wd[DATA_W-1:DATA_W/2];
    else merge[DATA_W/2-1:0] = wd[DATA_W/2-1:0];
  endfunction

  assign reg_sel   = addr_q[3:1];
  assign is_sample = (reg_sel == 3'd2);
  assign is_coeff  = (reg_sel >= 3'd3) && (reg_sel <= 3'd6);
  assign is_ncs    = (reg_sel == 3'd7);
  assign coeff_sel = IDX_W'(reg_sel - 3'd3);
  assign seq_busy  = (cstate_q != C_IDLE);

  // Writes to read-only registers and misaligned halfwords get the two-cycle error.
  assign bad_access = valid_q && ((write_q && (reg_sel <= 3'd1)) || (size_q && addr_q[0]));
  assign err1       = bad_access && !err2_q;

  // A rising modwait means the controller has taken the pending sample, so the stall lifts.
  assign sample_stall = valid_q && write_q && is_sample && !bad_access &&
                        ((dr_q && !modwait) || seq_busy);

  assign hready  = !(err1 || sample_stall);
  assign hresp   = err1 || err2_q;
  assign wr_done = valid_q && hready && !bad_access && write_q;
  assign rd_done = valid_q && hready && !bad_access && !write_q;
  assign err2_d  = err1;

  assign data_ready      = dr_q;
  assign sample_data     = sample_q;
  assign fir_coefficient = coeff_q[idx_q];

`ifdef FIR_ERR_STICKY_EN
  logic sticky_q, sticky_d;

  always_comb begin
    sticky_d = sticky_q;
    if (rd_done && (reg_sel == 3'd0)) sticky_d = 1'b0;
    if (err) sticky_d = 1'b1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) sticky_q <= 1'b0;
    else        sticky_q <= sticky_d;
  end

  assign err_bit = sticky_q;
`else
  assign err_bit = err;
`endif

  always_comb begin
    rd_val = '0;
    case (reg_sel)
      3'd0: begin
        rd_val[0] = modwait | dr_q;
        rd_val[8] = err_bit;
      end
      3'd1:    rd_val = fir_out;
      3'd2:    rd_val = sample_q;
      3'd7:    rd_val = {{(DATA_W-1){1'b0}}, ncs_q};
      default: rd_val = coeff_q[coeff_sel];
    endcase
    hrdata = (valid_q && !write_q && !bad_access) ? rd_val : '0;
  end

  always_comb begin
    cstate_d   = cstate_q;
    idx_d      = idx_q;
    load_coeff = 1'b0;
    seq_clear  = 1'b0;
    case (cstate_q)
      C_IDLE: if (ncs_q && !modwait && !dr_q) cstate_d = C_REQ;
      C_REQ: begin
        load_coeff = 1'b1;
        if (modwait) cstate_d = C_WAIT;
      end
      C_WAIT: begin
        if (!modwait) begin
          if (idx_q == IDX_W'(NUM_COEFF - 1)) begin
            idx_d     = '0;
            seq_clear = 1'b1;
            cstate_d  = C_IDLE;
          end else begin
            idx_d    = idx_q + 1'b1;
            cstate_d = C_REQ;
          end
        end
      end
      default: cstate_d = C_IDLE;
    endcase
  end

  always_comb begin
    valid_d  = valid_q;
    addr_d   = addr_q;
    size_d   = size_q;
    write_d  = write_q;
    sample_d = sample_q;
    coeff_d  = coeff_q;
    ncs_d    = ncs_q;
    dr_d     = dr_q;
    if (hready) begin
      valid_d = hsel && htrans[1];
      addr_d  = haddr;
      size_d  = hsize;
      write_d = hwrite;
    end
    if (dr_q && modwait) dr_d = 1'b0;
    if (wr_done && is_sample) begin
      sample_d = merge(sample_q, hwdata, size_q, addr_q[0]);
      dr_d     = 1'b1;
    end
    if (wr_done && is_coeff)
      coeff_d[coeff_sel] = merge(coeff_q[coeff_sel], hwdata, size_q, addr_q[0]);
    // Only the low byte lane carries bit0; the register is frozen while sequencing.
    if (wr_done && is_ncs && !seq_busy && (size_q || !addr_q[0])) ncs_d = hwdata[0];
    if (seq_clear) ncs_d = 1'b0;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      valid_q  <= 1'b0;
      addr_q   <= '0;
      size_q   <= 1'b0;
      write_q  <= 1'b0;
      err2_q   <= 1'b0;
      dr_q     <= 1'b0;
      sample_q <= '0;
      for (int i = 0; i < NUM_COEFF; i++) coeff_q[i] <= '0;
      ncs_q    <= 1'b0;
      cstate_q <= C_IDLE;
      idx_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      write_q  <= write_d;
      err2_q   <= err2_d;
      dr_q     <= dr_d;
      sample_q <= sample_d;
      coeff_q  <= coeff_d;
      ncs_q    <= ncs_d;
      cstate_q <= cstate_d;
      idx_q    <= idx_d;
    end
  end
endmodule
